// File: rtl/ftdi_tx_if.sv
// Fabric-side byte stream plus FTDI 245 synchronous-FIFO transmit pins.
// master drives bytes and bus status, slave is the transmitter.
`timescale 1ns/1ps
interface ftdi_tx_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        rx_busy;
    logic        txe_n;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        wr_n;
    logic        siwu_n;
    logic [AW:0] level;

    modport master (
        output in_data, in_valid, flush, rx_busy, txe_n,
        input  in_ready, data_out, data_oe, wr_n, siwu_n, level
    );

    modport slave (
        input  in_data, in_valid, flush, rx_busy, txe_n,
        output in_ready, data_out, data_oe, wr_n, siwu_n, level
    );
endinterface

// File: rtl/ftdi_tx.sv
// FT232H 245-sync transmit path: byte FIFO, txe_n/wr_n write engine,
// bus turnaround against the receive path, and siwu_n flush strobe.
`timescale 1ns/1ps
module ftdi_tx #(
    parameter int DEPTH = 16
) (
    input logic   clk_60,
    input logic   rst,
    ftdi_tx_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        TURN,
        SEND
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    logic        wr_n_q, wr_n_d;
    logic        oe_q, oe_d;
    logic        siwu_n_q, siwu_n_d;
    logic        flush_pending_q, flush_pending_d;
    logic        push, pop, last, fire;

    always_comb begin
        push = bus.in_valid && (level_q != FULL);
        // FTDI takes the head on any edge where our registered strobe is low
        pop  = !wr_n_q && !bus.txe_n && (level_q != '0);
        last = (level_q == ONE) && pop && !push;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + ONE;
            2'b01:   level_d = level_q - ONE;
            default: level_d = level_q;
        endcase

        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (level_q != '0 && !bus.txe_n && !bus.rx_busy)
                    state_d = TURN;
            end
            TURN: begin
                if (bus.rx_busy || bus.txe_n)
                    state_d = IDLE;
                else
                    state_d = SEND;
            end
            SEND: begin
                if (bus.txe_n || bus.rx_busy || last)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        wr_n_d = (state_d != SEND);
        oe_d   = (state_d != IDLE);

        fire = flush_pending_q && (state_q == IDLE) && (level_q == '0)
            && !bus.txe_n && !bus.rx_busy;
        siwu_n_d        = !fire;
        flush_pending_d = fire ? 1'b0 : (flush_pending_q | bus.flush);
    end

    always_ff @(posedge clk_60) begin
        if (rst) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= '0;
            wr_n_q          <= 1'b1;
            oe_q            <= 1'b0;
            siwu_n_q        <= 1'b1;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            level_q         <= level_d;
            wr_n_q          <= wr_n_d;
            oe_q            <= oe_d;
            siwu_n_q        <= siwu_n_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    // Storage needs no reset; emptiness is tracked by level_q alone
    always_ff @(posedge clk_60) begin
        if (push && !rst)
            mem_q[wr_ptr_q] <= bus.in_data;
    end

    assign bus.in_ready = (level_q != FULL);
    assign bus.data_out = (level_q == '0) ? 8'h00 : mem_q[rd_ptr_q];
    assign bus.data_oe  = oe_q;
    assign bus.wr_n     = wr_n_q;
    assign bus.siwu_n   = siwu_n_q;
    assign bus.level    = level_q;
endmodule
